// File: rtl/voxel_pkg.sv
// ---------------------------------------------------------------------------
// voxel_pkg
// Shared definitions for the voxel accumulator and its neighbours:
//   GRID_BITS     index bits per axis
//   VOXEL_DEPTH   number of voxels in the grid (2^(3*GRID_BITS))
//   voxel_word_t  BRAM word layout {isum[15:0], count[15:0]}
//   acc_state_t   accumulator FSM state encoding
//   sat_add16     16-bit add clipped at 0xFFFF
// ---------------------------------------------------------------------------
package voxel_pkg;

  localparam int GRID_BITS   = 5;
  localparam int VOXEL_DEPTH = 1 << (3 * GRID_BITS);

  typedef struct packed {
    logic [15:0] isum;
    logic [15:0] count;
  } voxel_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } acc_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/voxel_accumulator.sv
// ---------------------------------------------------------------------------
// voxel_accumulator
// Read-modify-write front end of the voxel BRAM. Each accepted point bumps
// the per-voxel count and intensity sum (both saturating at 0xFFFF). A level
// clear request sweeps zeros over the whole grid.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pt_valid / pt_ready      point handshake
//   pt_x, pt_y, pt_z, pt_int voxel indices and intensity of the point
//   clear_req / clear_done   grid clear request (level) / completion pulse
//   busy                     high whenever the FSM is not IDLE
//   bram_*                   BRAM port; bram_rdata valid the cycle after
//                            bram_read_en
//
// Optional build macro VOXEL_ACC_STATS_EN adds:
//   pts_accepted  wrapping count of accepted points
//   sat_events    count of saturating writes, sticks at 0xFFFF
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a point; clear_req takes priority
// READ  | read of the latched voxel address issued
// WRITE | read data present, updated word written back
// CLEAR | one zero write per cycle, address = sweep counter
// ---------------------------------------------------------------------------
module voxel_accumulator #(
  parameter int GRID_BITS = 5,
  parameter int ADDR_W    = 15,
  parameter int INT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [GRID_BITS-1:0] pt_x,
  input  logic [GRID_BITS-1:0] pt_y,
  input  logic [GRID_BITS-1:0] pt_z,
  input  logic [INT_W-1:0]     pt_int,
  input  logic                 clear_req,
  output logic                 clear_done,
  output logic                 busy,
  output logic                 bram_read_en,
  output logic                 bram_write_en,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic [31:0]          bram_wdata,
  input  logic [31:0]          bram_rdata
`ifdef VOXEL_ACC_STATS_EN
  ,
  output logic [31:0]          pts_accepted,
  output logic [15:0]          sat_events
`endif
);

  import voxel_pkg::*;

  // The counter carries one spare bit so the terminal compare never wraps.
  localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};

  acc_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INT_W-1:0]    int_q, int_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                accept;

  voxel_word_t         rd_w;
  voxel_word_t         wr_w;

  assign accept = (state_q == IDLE) && !clear_req && pt_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    int_d   = int_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end else if (pt_valid) begin
          addr_d  = ADDR_W'({pt_z, pt_y, pt_x});
          int_d   = pt_int;
          state_d = READ;
        end
      end
      READ:  state_d = WRITE;
      WRITE: state_d = IDLE;
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CLR_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      int_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      int_q   <= int_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Updated voxel word; only meaningful in WRITE, where bram_rdata is valid.
  always_comb begin
    rd_w       = voxel_word_t'(bram_rdata);
    wr_w.count = sat_add16(rd_w.count, 16'd1);
    wr_w.isum  = sat_add16(rd_w.isum, 16'(int_q));
  end

  // Outputs are forced to their idle values while rst is high, so a reset
  // landing in WRITE or CLEAR suppresses that cycle's BRAM write too.
  assign pt_ready      = !rst && (state_q == IDLE) && !clear_req;
  assign busy          = !rst && (state_q != IDLE);
  assign bram_read_en  = !rst && (state_q == READ);
  assign bram_write_en = !rst && ((state_q == WRITE) || (state_q == CLEAR));
  assign clear_done    = !rst && done_q;

  always_comb begin
    bram_addr  = '0;
    bram_wdata = '0;
    if (!rst) begin
      case (state_q)
        READ:  bram_addr = addr_q;
        WRITE: begin
          bram_addr  = addr_q;
          bram_wdata = wr_w;
        end
        CLEAR: bram_addr = cnt_q[ADDR_W-1:0];
        default: bram_addr = '0;
      endcase
    end
  end

`ifdef VOXEL_ACC_STATS_EN
  logic [31:0] pts_q;
  logic [15:0] sat_q;
  logic        sat_hit;

  assign sat_hit = (rd_w.count == 16'hFFFF) ||
                   (({1'b0, rd_w.isum} + 17'(int_q)) > 17'h0FFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      pts_q <= '0;
      sat_q <= '0;
    end else begin
      if (accept)
        pts_q <= pts_q + 32'd1;
      if ((state_q == WRITE) && sat_hit && (sat_q != 16'hFFFF))
        sat_q <= sat_q + 16'd1;
    end
  end

  assign pts_accepted = pts_q;
  assign sat_events   = sat_q;
`endif

endmodule

// File: tb/tb_voxel_accumulator.sv
// ---------------------------------------------------------------------------
// tb_voxel_accumulator
// Directed bench for voxel_accumulator with a behavioural 32K x 32 BRAM
// (registered read). Define VOXEL_ACC_STATS_EN to also cover the counters.
// ---------------------------------------------------------------------------
module tb_voxel_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [4:0]  pt_x = '0, pt_y = '0, pt_z = '0;
  logic [7:0]  pt_int = '0;
  logic        clear_req = 1'b0;
  logic        clear_done;
  logic        busy;
  logic        bram_read_en;
  logic        bram_write_en;
  logic [14:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;
`ifdef VOXEL_ACC_STATS_EN
  logic [31:0] pts_accepted;
  logic [15:0] sat_events;
`endif

  logic [31:0] mem [0:32767];
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  voxel_accumulator #(.GRID_BITS(5), .ADDR_W(15), .INT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .pt_valid      (pt_valid),
    .pt_ready      (pt_ready),
    .pt_x          (pt_x),
    .pt_y          (pt_y),
    .pt_z          (pt_z),
    .pt_int        (pt_int),
    .clear_req     (clear_req),
    .clear_done    (clear_done),
    .busy          (busy),
    .bram_read_en  (bram_read_en),
    .bram_write_en (bram_write_en),
    .bram_addr     (bram_addr),
    .bram_wdata    (bram_wdata),
    .bram_rdata    (bram_rdata)
`ifdef VOXEL_ACC_STATS_EN
    ,
    .pts_accepted  (pts_accepted),
    .sat_events    (sat_events)
`endif
  );

  always @(posedge clk) begin
    if (bram_read_en)
      bram_rdata <= mem[bram_addr];
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (bram_write_en)
      mem[bram_addr] <= bram_wdata;
  end

  always @(negedge clk) begin
    if (clear_done) done_pulses++;
    if (bram_read_en && bram_write_en) both_hi++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pl_addr = 15'(a);
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Starts at a negedge in IDLE, returns at a negedge back in IDLE.
  task automatic run_point(input logic [4:0] x, input logic [4:0] y, input logic [4:0] z,
                           input logic [7:0] it, output logic [31:0] wd);
    logic got;
    got = 1'b0;
    wd = '0;
    pt_x = x; pt_y = y; pt_z = z; pt_int = it;
    pt_valid = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bram_read_en) pt_valid = 1'b0;
      if (bram_write_en) begin
        wd = bram_wdata;
        got = 1'b1;
      end
    end
    pt_valid = 1'b0;
    if (!got) chk("point_write_seen", 64'(got), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int bad;
    int nz;
    int nw;
    int sent;
    int wcyc [3];
    logic [31:0] wd;

    repeat (2) @(negedge clk);
    chk("rst_pt_ready", 64'(pt_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_read_en", 64'(bram_read_en), 64'd0);
    chk("rst_write_en", 64'(bram_write_en), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_wdata", 64'(bram_wdata), 64'd0);
    chk("rst_clear_done", 64'(clear_done), 64'd0);

    preload(0, 32'hA5A5_0001);
    preload(100, 32'h1234_5678);
    preload(32767, 32'hDEAD_BEEF);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_pt_ready", 64'(pt_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    // clear_req and pt_valid together: clear wins, point waits
    clear_req = 1'b1;
    pt_valid = 1'b1; pt_x = 5'd7; pt_y = 5'd7; pt_z = 5'd7; pt_int = 8'd1;
    #1;
    chk("clr_ready_blocked", 64'(pt_ready), 64'd0);
    @(negedge clk);
    clear_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 32768; i++) begin
      if (i > 0) @(negedge clk);
      if (!(bram_write_en && !bram_read_en && bram_addr == 15'(i) && bram_wdata == 32'd0 &&
            busy && !pt_ready && !clear_done))
        bad++;
    end
    chk("clr_sweep_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    chk("clr_done_pulse", 64'(clear_done), 64'd1);
    chk("clr_busy_after", 64'(busy), 64'd0);
    chk("clr_ready_after", 64'(pt_ready), 64'd1);
    chk("clr_no_write_after", 64'(bram_write_en), 64'd0);
    nz = 0;
    for (int i = 0; i < 32768; i++) if (mem[i] != 32'd0) nz++;
    chk("clr_mem_nonzero", 64'(nz), 64'd0);
    @(negedge clk);
    pt_valid = 1'b0;
    chk("clr_done_once", 64'(clear_done), 64'd0);
    chk("clr_pt_read_en", 64'(bram_read_en), 64'd1);
    chk("clr_pt_addr", 64'(bram_addr), 64'd7399);
    @(negedge clk);
    chk("clr_pt_wdata", 64'(bram_wdata), 64'h0001_0001);
    @(negedge clk);
    chk("clr_done_count", 64'(done_pulses), 64'd1);

    // single point (3,2,1) int 5 -> addr 1091
    pt_valid = 1'b1; pt_x = 5'd3; pt_y = 5'd2; pt_z = 5'd1; pt_int = 8'd5;
    #1;
    chk("sp_ready", 64'(pt_ready), 64'd1);
    @(negedge clk);
    pt_valid = 1'b0;
    chk("sp_read_en", 64'(bram_read_en), 64'd1);
    chk("sp_read_addr", 64'(bram_addr), 64'd1091);
    chk("sp_read_ready", 64'(pt_ready), 64'd0);
    chk("sp_read_no_we", 64'(bram_write_en), 64'd0);
    @(negedge clk);
    chk("sp_write_en", 64'(bram_write_en), 64'd1);
    chk("sp_write_no_re", 64'(bram_read_en), 64'd0);
    chk("sp_write_addr", 64'(bram_addr), 64'd1091);
    chk("sp_wdata", 64'(bram_wdata), 64'h0005_0001);
    chk("sp_write_ready", 64'(pt_ready), 64'd0);
    @(negedge clk);
    chk("sp_back_ready", 64'(pt_ready), 64'd1);
    chk("sp_mem", 64'(mem[1091]), 64'h0005_0001);

    // three back-to-back points to voxel 0
    nw = 0; sent = 1;
    pt_valid = 1'b1; pt_x = 5'd0; pt_y = 5'd0; pt_z = 5'd0; pt_int = 8'd10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bram_write_en && nw < 3) begin
        wcyc[nw] = c;
        nw++;
      end
      if (pt_ready) begin
        if (sent < 3) begin
          pt_int = (sent == 1) ? 8'd20 : 8'd30;
          sent++;
        end else begin
          pt_valid = 1'b0;
        end
      end
    end
    pt_valid = 1'b0;
    chk("b2b_writes", 64'(nw), 64'd3);
    chk("b2b_first_lat", 64'(wcyc[0]), 64'd2);
    chk("b2b_gap0", 64'(wcyc[1] - wcyc[0]), 64'd3);
    chk("b2b_gap1", 64'(wcyc[2] - wcyc[1]), 64'd3);
    chk("b2b_mem", 64'(mem[0]), 64'h003C_0003);

    // saturation cases
    preload(6308, 32'hFFF0_FFFF);
    run_point(5'd4, 5'd5, 5'd6, 8'h20, wd);
    chk("sat_both_wdata", 64'(wd), 64'hFFFF_FFFF);
    chk("sat_both_mem", 64'(mem[6308]), 64'hFFFF_FFFF);
`ifdef VOXEL_ACC_STATS_EN
    chk("stat_sat_1", 64'(sat_events), 64'd1);
`endif
    preload(1, 32'h0000_FFFF);
    run_point(5'd1, 5'd0, 5'd0, 8'd1, wd);
    chk("sat_count_wdata", 64'(wd), 64'h0001_FFFF);
    preload(2, 32'hFFFE_0005);
    run_point(5'd2, 5'd0, 5'd0, 8'd3, wd);
    chk("sat_isum_wdata", 64'(wd), 64'hFFFF_0006);
    preload(3, 32'hFFFE_0005);
    run_point(5'd3, 5'd0, 5'd0, 8'd1, wd);
    chk("nosat_edge_wdata", 64'(wd), 64'hFFFF_0006);
`ifdef VOXEL_ACC_STATS_EN
    chk("stat_sat_3", 64'(sat_events), 64'd3);
    chk("stat_pts_9", 64'(pts_accepted), 64'd9);
`endif

    // reset during WRITE, voxel (1,1,1) = addr 1057
    pt_valid = 1'b1; pt_x = 5'd1; pt_y = 5'd1; pt_z = 5'd1; pt_int = 8'd9;
    @(negedge clk);
    pt_valid = 1'b0;
    chk("rw_read_en", 64'(bram_read_en), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rw_no_write", 64'(bram_write_en), 64'd0);
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_addr", 64'(bram_addr), 64'd0);
    chk("rw_wdata", 64'(bram_wdata), 64'd0);
    chk("rw_ready", 64'(pt_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rw_next_no_write", 64'(bram_write_en), 64'd0);
    chk("rw_next_busy", 64'(busy), 64'd0);
    chk("rw_next_ready", 64'(pt_ready), 64'd1);
    @(negedge clk);
    chk("rw_mem_unchanged", 64'(mem[1057]), 64'd0);
`ifdef VOXEL_ACC_STATS_EN
    chk("stat_rst_sat", 64'(sat_events), 64'd0);
    chk("stat_rst_pts", 64'(pts_accepted), 64'd0);
`endif
    run_point(5'd1, 5'd1, 5'd1, 8'd9, wd);
    chk("rw_retry_wdata", 64'(wd), 64'h0009_0001);
    chk("rw_retry_mem", 64'(mem[1057]), 64'h0009_0001);
`ifdef VOXEL_ACC_STATS_EN
    chk("stat_pts_after", 64'(pts_accepted), 64'd1);
`endif

    // reset mid-CLEAR at counter 100
    preload(99, 32'h1111_1111);
    preload(100, 32'h2222_2222);
    preload(101, 32'h3333_3333);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int k = 0; k < 200 && !(bram_write_en && bram_addr == 15'd100); k++)
      @(negedge clk);
    chk("rc_reach_100", 64'(bram_addr), 64'd100);
    rst = 1'b1;
    #1;
    chk("rc_no_write", 64'(bram_write_en), 64'd0);
    @(negedge clk);
    chk("rc_busy_after", 64'(busy), 64'd0);
    chk("rc_done_after", 64'(clear_done), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rc_idle_busy", 64'(busy), 64'd0);
    chk("rc_done_total", 64'(done_pulses), 64'd1);
    chk("rc_mem99", 64'(mem[99]), 64'd0);
    chk("rc_mem100", 64'(mem[100]), 64'h2222_2222);
    chk("rc_mem101", 64'(mem[101]), 64'h3333_3333);
    chk("rw_exclusive", 64'(both_hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
